// File: rtl/e_alu_md.sv
// E-stage arithmetic unit: combinational ALU with overflow/address exceptions,
// plus a multi-cycle multiply/divide engine owning the HI/LO registers.
module e_alu_md #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       aluOp,
    input  logic             isAri,
    input  logic [3:0]       lsOp_E,
    input  logic [3:0]       mdOp,
    input  logic             req,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] mdResult,
    output logic [4:0]       E_excCode,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    // Full-width product; sign-extending to 2*WIDTH makes the low half of an
    // unsigned multiply equal to the signed product.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic is_signed,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ea, eb;
        ea = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division runs on magnitudes, which
    // yields truncation toward zero and MIN / -1 = {0, MIN} without a special case.
    function automatic logic [2*WIDTH-1:0] div_full(input logic is_signed,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] ma, mb, q, r;
        logic             neg_q, neg_r;
        neg_r = is_signed & a[WIDTH-1];
        neg_q = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        ma    = (is_signed && a[WIDTH-1]) ? -a : a;
        mb    = (is_signed && b[WIDTH-1]) ? -b : b;
        q     = ma / mb;
        r     = ma % mb;
        return {(neg_r ? -r : r), (neg_q ? -q : q)};
    endfunction

    // ---------------- ALU and exception detection ----------------
    logic signed [WIDTH:0] a_ext, b_ext, sum_ext, diff_ext;
    logic add_ov, sub_ov, op_ov, is_load, is_store;

    assign a_ext    = {srcA[WIDTH-1], srcA};
    assign b_ext    = {srcB[WIDTH-1], srcB};
    assign sum_ext  = a_ext + b_ext;
    assign diff_ext = a_ext - b_ext;
    assign add_ov   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    assign sub_ov   = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
    assign op_ov    = (aluOp == 4'd3) ? add_ov : ((aluOp == 4'd4) ? sub_ov : 1'b0);
    assign is_load  = (lsOp_E >= 4'd1) && (lsOp_E <= 4'd5);
    assign is_store = (lsOp_E >= 4'd6) && (lsOp_E <= 4'd8);

    always_comb begin
        aluResult = '0;
        case (aluOp)
            4'd1:    aluResult = srcA & srcB;
            4'd2:    aluResult = srcA | srcB;
            4'd3:    aluResult = sum_ext[WIDTH-1:0];
            4'd4:    aluResult = diff_ext[WIDTH-1:0];
            4'd5:    aluResult = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            4'd6:    aluResult = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            4'd7:    aluResult = srcA ^ srcB;
            4'd8:    aluResult = ~(srcA | srcB);
            4'd9:    aluResult = srcB << (WIDTH / 2);
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        E_excCode = 5'd0;
        if (isAri && op_ov)          E_excCode = 5'd12;
        else if (is_load && add_ov)  E_excCode = 5'd4;
        else if (is_store && add_ov) E_excCode = 5'd5;
    end

    // ---------------- multiply/divide engine ----------------
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       op_md;
    logic             is_start, issue, mt_wr, finish;
    logic [2*WIDTH-1:0] mul_res, div_res;

    assign is_start = (mdOp >= 4'd1) && (mdOp <= 4'd4);
    assign issue    = is_start && !req && (state == IDLE);
    assign mt_wr    = ((mdOp == 4'd7) || (mdOp == 4'd8)) && !req && (state == IDLE);
    assign finish   = (state == RUN) && (cnt == CNT_W'(1));
    assign mul_res  = mul_full(op_md == 4'd1, op_a, op_b);
    assign div_res  = div_full(op_md == 4'd3, op_a, op_b);
    assign busy     = (state == RUN);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (issue) begin
                state_nx = RUN;
                cnt_nx   = (mdOp <= 4'd2) ? MUL_N : DIV_N;
            end
            RUN: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_md <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (issue) begin
                op_a  <= srcA;
                op_b  <= srcB;
                op_md <= mdOp;
            end
            if (finish) begin
                if (op_md <= 4'd2)     {hi, lo} <= mul_res;
                else if (op_b != '0)   {hi, lo} <= div_res;
            end else if (mt_wr) begin
                if (mdOp == 4'd7) hi <= srcA;
                else              lo <= srcA;
            end
        end
    end

    assign mdResult = (mdOp == 4'd5) ? hi : ((mdOp == 4'd6) ? lo : '0);
endmodule

// File: tb/tb_e_alu_md.sv
// Randomized self-checking bench for e_alu_md against a behavioural model
// of the ALU, exception priority and HI/LO arithmetic.
module tb_e_alu_md;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] srcA, srcB, aluResult, mdResult, hi, lo;
    logic [3:0]  aluOp, lsOp_E, mdOp;
    logic        isAri, req, busy;
    logic [4:0]  E_excCode;

    logic [15:0] srcA16, srcB16, aluResult16, mdResult16, hi16, lo16;
    logic [3:0]  aluOp16, lsOp16, mdOp16;
    logic        isAri16, req16, busy16;
    logic [4:0]  exc16;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    e_alu_md #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .aluOp(aluOp),
        .isAri(isAri), .lsOp_E(lsOp_E), .mdOp(mdOp), .req(req),
        .aluResult(aluResult), .mdResult(mdResult), .E_excCode(E_excCode),
        .busy(busy), .hi(hi), .lo(lo));

    e_alu_md #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset), .srcA(srcA16), .srcB(srcB16), .aluOp(aluOp16),
        .isAri(isAri16), .lsOp_E(lsOp16), .mdOp(mdOp16), .req(req16),
        .aluResult(aluResult16), .mdResult(mdResult16), .E_excCode(exc16),
        .busy(busy16), .hi(hi16), .lo(lo16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1: return a & b;
            4'd2: return a | b;
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a ^ b;
            4'd8: return ~(a | b);
            4'd9: return {b[15:0], 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [4:0] exc_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic ari, input logic [3:0] ls);
        longint s, d, lim;
        logic aov, dov;
        lim = 64'sh80000000;
        s   = longint'($signed(a)) + longint'($signed(b));
        d   = longint'($signed(a)) - longint'($signed(b));
        aov = (s >= lim) || (s < -lim);
        dov = (d >= lim) || (d < -lim);
        if (ari && ((op == 4'd3 && aov) || (op == 4'd4 && dov))) return 5'd12;
        if (ls >= 4'd1 && ls <= 4'd5 && aov) return 5'd4;
        if (ls >= 4'd6 && ls <= 4'd8 && aov) return 5'd5;
        return 5'd0;
    endfunction

    task automatic md_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        logic [63:0] p;
        case (op)
            4'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {m_hi, m_lo} = p; end
            4'd2: begin p = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = p; end
            4'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic ari, input logic [3:0] ls, input logic [31:0] exp_r, input logic [4:0] exp_e);
        aluOp = op; srcA = a; srcB = b; isAri = ari; lsOp_E = ls;
        #1;
        check({tag, "_res"}, aluResult, exp_r);
        check({tag, "_exc"}, {27'h0, E_excCode}, {27'h0, exp_e});
    endtask

    task automatic md_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq);
        int n;
        int exp_n;
        tick();
        srcA = a; srcB = b; mdOp = op; req = rq;
        tick();
        mdOp = 4'd0; req = 1'b0;
        n = 0;
        while (busy && n < 200) begin n++; tick(); end
        exp_n = rq ? 0 : ((op <= 4'd2) ? 5 : 10);
        check({tag, "_busy"}, 32'(n), 32'(exp_n));
        if (!rq) md_ref(op, a, b);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    task automatic md_mt(input string tag, input logic [3:0] op, input logic [31:0] a, input logic rq);
        tick();
        srcA = a; mdOp = op; req = rq;
        tick();
        mdOp = 4'd0; req = 1'b0;
        if (!rq) md_ref(op, a, 32'h0);
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  op, ls;
        logic [31:0] a, b, old_hi;
        logic        ari;
        int          n;
        reset = 1'b0; srcA = 0; srcB = 0; aluOp = 0; isAri = 0; lsOp_E = 0; mdOp = 0; req = 0;
        srcA16 = 0; srcB16 = 0; aluOp16 = 0; isAri16 = 0; lsOp16 = 0; mdOp16 = 0; req16 = 0;
        m_hi = 0; m_lo = 0;
        #12;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(negedge clk) reset = 1'b1;

        alu_case("add_ov", 4'd3, 32'h7FFFFFFF, 32'h1, 1'b1, 4'd0, 32'h80000000, 5'd12);
        alu_case("adel",   4'd3, 32'h7FFFFFFF, 32'h1, 1'b0, 4'd1, 32'h80000000, 5'd4);
        alu_case("ades",   4'd3, 32'h7FFFFFFF, 32'h1, 1'b0, 4'd7, 32'h80000000, 5'd5);
        alu_case("sub_ov", 4'd4, 32'h80000000, 32'h1, 1'b1, 4'd0, 32'h7FFFFFFF, 5'd12);
        alu_case("no_ades", 4'd3, 32'h5, 32'h3, 1'b0, 4'd6, 32'h8, 5'd0);
        alu_case("sub_st", 4'd4, 32'h80000000, 32'h1, 1'b0, 4'd6, 32'h7FFFFFFF, 5'd0);
        alu_case("lui",    4'd9, 32'h0, 32'h00001234, 1'b0, 4'd0, 32'h12340000, 5'd0);
        alu_case("slt",    4'd5, 32'hFFFFFFFF, 32'h1, 1'b0, 4'd0, 32'h1, 5'd0);
        alu_case("sltu",   4'd6, 32'hFFFFFFFF, 32'h1, 1'b0, 4'd0, 32'h0, 5'd0);
        alu_case("badop",  4'd15, 32'hFFFFFFFF, 32'h1, 1'b0, 4'd0, 32'h0, 5'd0);

        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 15));
            ls  = 4'($urandom_range(0, 15));
            ari = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 2) == 0) ? (32'h7FFFFFF0 + 32'($urandom_range(0, 31))) : $urandom();
            b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : $urandom();
            alu_case("rnd_alu", op, a, b, ari, ls, alu_ref(op, a, b), exc_ref(op, a, b, ari, ls));
        end
        aluOp = 0; isAri = 0; lsOp_E = 0;

        md_op("mult", 4'd1, 32'hFFFFFFFE, 32'h3, 1'b0);
        check("mult_hi_k", hi, 32'hFFFFFFFF);
        check("mult_lo_k", lo, 32'hFFFFFFFA);
        md_op("divu", 4'd4, 32'd7, 32'd2, 1'b0);
        check("divu_lo_k", lo, 32'd3);
        check("divu_hi_k", hi, 32'd1);
        md_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_lo_k", lo, 32'hFFFFFFFD);
        check("div_hi_k", hi, 32'hFFFFFFFF);
        md_op("div0", 4'd3, 32'd5, 32'd0, 1'b0);
        check("div0_lo_k", lo, 32'hFFFFFFFD);
        md_op("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("divmin_lo_k", lo, 32'h80000000);
        check("divmin_hi_k", hi, 32'h0);
        md_op("mult_req", 4'd1, 32'd5, 32'd6, 1'b1);
        md_mt("mtlo_req", 4'd8, 32'h1234, 1'b1);

        tick();
        srcA = 32'd100; srcB = 32'd7; mdOp = 4'd4;
        tick();
        mdOp = 0; req = 1'b1;
        n = 0;
        while (busy && n < 200) begin n++; tick(); end
        req = 1'b0;
        md_ref(4'd4, 32'd100, 32'd7);
        check("req_run_busy", 32'(n), 32'd10);
        check("req_run_lo", lo, m_lo);
        check("req_run_hi", hi, m_hi);

        tick();
        srcA = 32'd3; srcB = 32'd4; mdOp = 4'd1;
        tick();
        old_hi = hi;
        srcA = 32'hABCD; mdOp = 4'd7;
        tick();
        check("mthi_busy_hold", hi, old_hi);
        mdOp = 0;
        n = 0;
        while (busy && n < 200) begin n++; tick(); end
        md_ref(4'd1, 32'd3, 32'd4);
        check("mthi_busy_hi", hi, m_hi);
        check("mthi_busy_lo", lo, m_lo);

        md_mt("mthi", 4'd7, 32'hABCD, 1'b0);
        mdOp = 4'd5; #1;
        check("mfhi", mdResult, 32'hABCD);
        mdOp = 4'd6; #1;
        check("mflo", mdResult, m_lo);
        mdOp = 4'd0; #1;
        check("mfnone", mdResult, 32'h0);

        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 5));
            op = (op == 4'd5) ? 4'd7 : ((op == 4'd0) ? 4'd8 : op);
            a  = $urandom();
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
                default: b = $urandom();
            endcase
            if (op >= 4'd7) md_mt("rnd_mt", op, a, 1'($urandom_range(0, 1)));
            else            md_op("rnd_md", op, a, b, 1'($urandom_range(0, 3) == 0));
        end

        md_mt("pre_rst", 4'd7, 32'h55, 1'b0);
        tick();
        srcA = 32'd50; srcB = 32'd3; mdOp = 4'd3;
        tick();
        mdOp = 0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk) reset = 1'b1;
        m_hi = 0; m_lo = 0;
        tick();
        check("postrst_busy", {31'h0, busy}, 32'h0);

        srcA16 = 16'hFFFF; srcB16 = 16'hFFFF; mdOp16 = 4'd2;
        tick();
        mdOp16 = 0;
        n = 0;
        while (busy16 && n < 50) begin n++; tick(); end
        check("w16_busy", 32'(n), 32'd1);
        check("w16_hi", {16'h0, hi16}, 32'h0000FFFE);
        check("w16_lo", {16'h0, lo16}, 32'h00000001);
        aluOp16 = 4'd9; srcB16 = 16'h0012; #1;
        check("w16_lui", {16'h0, aluResult16}, 32'h00001200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
